// File: rtl/floor_call_panel.sv
// Floor call registrar: synchronises and debounces four floor buttons, latches pending calls,
// clears them on door-open service and publishes lamps, served pulses and a nearest-call hint.
module floor_call_panel #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] button_raw,
   input  logic [1:0] current_floor,
   input  logic       door_open,
   input  logic       overload,
   output logic [3:0] floor_request,
   output logic [3:0] call_lamp,
   output logic [3:0] served,
   output logic [1:0] next_target,
   output logic       target_valid
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [3:0]    sync1_r, sync2_r;
   logic [3:0]    db_r, db_prev_r;
   logic [CW-1:0] cnt_r [4];
   logic [3:0]    pending_r, lamp_r, served_r;
   logic [1:0]    next_target_r;
   logic          target_valid_r;

   logic [3:0]    press_s, clear_s, pending_next_s, served_next_s;
   logic          svc_s;
   logic [1:0]    dist_s [4];
   logic [1:0]    best_s, best_dist_s;
   logic          found_s;

   // Synchroniser, debounce counters and the debounced level history
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r   <= 4'b0000;
         sync2_r   <= 4'b0000;
         db_r      <= 4'b0000;
         db_prev_r <= 4'b0000;
         for (int i = 0; i < 4; i++) begin
            cnt_r[i] <= '0;
         end
      end else begin
         sync1_r   <= button_raw;
         sync2_r   <= sync1_r;
         db_prev_r <= db_r;
         for (int i = 0; i < 4; i++) begin
            if (sync2_r[i] == db_r[i]) begin
               cnt_r[i] <= '0;
            end else if (cnt_r[i] == CNT_MAX) begin
               db_r[i]  <= ~db_r[i];
               cnt_r[i] <= '0;
            end else begin
               cnt_r[i] <= cnt_r[i] + CW'(1);
            end
         end
      end
   end

   // Call bookkeeping: a clear at the serviced floor beats a press on the same floor
   always_comb begin
      press_s = db_r & ~db_prev_r;
      svc_s   = door_open & ~overload;
      clear_s = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         clear_s[i] = svc_s & (current_floor == 2'(i));
      end
      pending_next_s = (pending_r | press_s) & ~clear_s;
      served_next_s  = clear_s & (pending_r | press_s);
   end

   // Nearest pending floor; scanning upward with <= lets the higher floor win ties
   always_comb begin
      best_s      = 2'd0;
      best_dist_s = 2'd3;
      found_s     = 1'b0;
      for (int i = 0; i < 4; i++) begin
         dist_s[i] = (2'(i) >= current_floor) ? (2'(i) - current_floor)
                                              : (current_floor - 2'(i));
         best_s      = (pending_r[i] && (!found_s || dist_s[i] <= best_dist_s)) ? 2'(i) : best_s;
         best_dist_s = (pending_r[i] && (!found_s || dist_s[i] <= best_dist_s)) ? dist_s[i] : best_dist_s;
         found_s     = found_s | pending_r[i];
      end
   end

   // Registered call state, lamps, served pulses and hint
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_r      <= 4'b0000;
         lamp_r         <= 4'b0000;
         served_r       <= 4'b0000;
         next_target_r  <= 2'd0;
         target_valid_r <= 1'b0;
      end else begin
         pending_r      <= pending_next_s;
         lamp_r         <= pending_next_s;
         served_r       <= served_next_s;
         target_valid_r <= found_s;
         if (found_s) begin
            next_target_r <= best_s;
         end else begin
            next_target_r <= next_target_r;
         end
      end
   end

   assign floor_request = pending_r;
   assign call_lamp     = lamp_r;
   assign served        = served_r;
   assign next_target   = next_target_r;
   assign target_valid  = target_valid_r;

endmodule

// File: tb/tb_floor_call_panel.sv
// Directed bench for floor_call_panel: table of nearest-call vectors plus hand-written
// sequences for reset, press latency, glitch rejection, service, overload and absorbed press.
module tb_floor_call_panel;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] button_raw;
   logic [1:0] current_floor;
   logic       door_open;
   logic       overload;
   logic [3:0] floor_request;
   logic [3:0] call_lamp;
   logic [3:0] served;
   logic [1:0] next_target;
   logic       target_valid;

   int checks = 0;
   int errors = 0;

   floor_call_panel #(.DEBOUNCE_CYCLES(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .button_raw    (button_raw),
      .current_floor (current_floor),
      .door_open     (door_open),
      .overload      (overload),
      .floor_request (floor_request),
      .call_lamp     (call_lamp),
      .served        (served),
      .next_target   (next_target),
      .target_valid  (target_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] mask;
      logic [1:0] cf;
      logic [1:0] exp_target;
   } hint_vec_t;

   hint_vec_t vecs [8];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      button_raw = 4'b0000;
      door_open  = 1'b0;
      overload   = 1'b0;
      rst        = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic press_mask(input logic [3:0] mask);
      button_raw = mask;
      repeat (8) step();
      button_raw = 4'b0000;
      repeat (8) step();
   endtask

   initial begin
      int pulses;
      logic fr_seen;

      vecs[0] = '{4'b1001, 2'd1, 2'd0};
      vecs[1] = '{4'b0101, 2'd1, 2'd2};
      vecs[2] = '{4'b0001, 2'd3, 2'd0};
      vecs[3] = '{4'b1000, 2'd0, 2'd3};
      vecs[4] = '{4'b1111, 2'd2, 2'd2};
      vecs[5] = '{4'b0110, 2'd0, 2'd1};
      vecs[6] = '{4'b1010, 2'd2, 2'd3};
      vecs[7] = '{4'b0011, 2'd3, 2'd1};

      current_floor = 2'd0;
      do_reset();
      check("reset_floor_request", {4'b0, floor_request}, 8'h00);
      check("reset_call_lamp", {4'b0, call_lamp}, 8'h00);
      check("reset_served", {4'b0, served}, 8'h00);
      check("reset_next_target", {6'b0, next_target}, 8'h00);
      check("reset_target_valid", {7'b0, target_valid}, 8'h00);

      // Press latency: sync1 captures at the next edge (E0)
      button_raw = 4'b0100;
      repeat (6) step();
      check("latency_before_e6", {4'b0, floor_request}, 8'h00);
      step();
      check("latency_at_e6", {4'b0, floor_request}, 8'h04);
      check("latency_hint_lag", {7'b0, target_valid}, 8'h00);
      step();
      check("latency_target_valid", {7'b0, target_valid}, 8'h01);
      check("latency_next_target", {6'b0, next_target}, 8'h02);
      button_raw = 4'b0000;

      // Glitch rejection
      do_reset();
      button_raw = 4'b0010;
      repeat (3) step();
      button_raw = 4'b0000;
      repeat (12) step();
      check("glitch_floor_request", {4'b0, floor_request}, 8'h00);

      // Nearest-call table
      for (int v = 0; v < 8; v++) begin
         current_floor = vecs[v].cf;
         do_reset();
         press_mask(vecs[v].mask);
         check($sformatf("hint%0d_floor_request", v), {4'b0, floor_request}, {4'b0, vecs[v].mask});
         check($sformatf("hint%0d_target_valid", v), {7'b0, target_valid}, 8'h01);
         check($sformatf("hint%0d_next_target", v), {6'b0, next_target}, {6'b0, vecs[v].exp_target});
      end

      // Service at floor 3
      current_floor = 2'd3;
      do_reset();
      press_mask(4'b1010);
      door_open = 1'b1;
      step();
      check("svc_served", {4'b0, served}, 8'h08);
      check("svc_floor_request", {4'b0, floor_request}, 8'h02);
      check("svc_call_lamp", {4'b0, call_lamp}, 8'h02);
      step();
      check("svc_served_once", {4'b0, served}, 8'h00);
      check("svc_floor_request_2", {4'b0, floor_request}, 8'h02);
      door_open = 1'b0;
      step();
      check("svc_next_target", {6'b0, next_target}, 8'h01);

      // Overload inhibits the clear
      do_reset();
      press_mask(4'b1010);
      overload  = 1'b1;
      door_open = 1'b1;
      step();
      check("ovl_served_1", {4'b0, served}, 8'h00);
      check("ovl_floor_request_1", {4'b0, floor_request}, 8'h0A);
      step();
      check("ovl_served_2", {4'b0, served}, 8'h00);
      check("ovl_floor_request_2", {4'b0, floor_request}, 8'h0A);
      overload = 1'b0;
      step();
      check("ovl_release_served", {4'b0, served}, 8'h08);
      check("ovl_release_floor_request", {4'b0, floor_request}, 8'h02);
      door_open = 1'b0;

      // Press at an open door is absorbed and acknowledged once
      current_floor = 2'd1;
      do_reset();
      door_open  = 1'b1;
      button_raw = 4'b0010;
      pulses  = 0;
      fr_seen = 1'b0;
      for (int c = 0; c < 14; c++) begin
         step();
         if (served == 4'b0010) pulses++;
         if (floor_request != 4'b0000) fr_seen = 1'b1;
      end
      check("absorb_pulses", 8'(pulses), 8'h01);
      check("absorb_no_latch", {7'b0, fr_seen}, 8'h00);
      check("absorb_target_valid", {7'b0, target_valid}, 8'h00);
      button_raw = 4'b0000;
      door_open  = 1'b0;
      repeat (10) step();
      check("absorb_after_release", {4'b0, floor_request}, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
